mem_port_arbiter: RTL

//  Shares one synchronous single-port SRAM between the CPU instruction-fetch and load/store requesters.

---
 rtl/cpu_mem_pkg.sv | 21 ++
 rtl/arb_starve_counter.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-side memory port arbiter.
//  - owner_e   : which requester owns the response returning next cycle
//  - DefaultStarveLimit : default data-grant run length before fetch is forced through
//  - StrbW     : byte-strobe width of the data port and SRAM write enable
//  - cnt_width : bits needed to count 0..limit inclusive
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam int unsigned DefaultStarveLimit = 4;
  localparam int unsigned StrbW = 4;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating up-counter used to bound how long fetch can be starved by the data port.
// Ports:
//  clk_i      clock
//  rst_ni     asynchronous active-low reset
//  inc_i      count one more data grant taken while fetch was waiting
//  clr_i      clear (has priority over inc_i)
//  at_limit_o counter has reached Limit
module arb_starve_counter #(
  parameter int unsigned Limit = 4,
  parameter int unsigned CntW  = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [CntW-1:0] LimitC = CntW'(Limit);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LimitC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LimitC);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port SRAM between instruction fetch and load/store.
// Data side wins by default; after STARVE_LIMIT consecutive data grants with fetch
// waiting, fetch is forced through once. One grant per cycle, response one cycle later.
// Ports:
//  clk, resetn                      clock, async active-low reset
//  inst_req/addr -> inst_addr_ok    fetch request / accept
//  inst_data_ok, inst_rdata         fetch response
//  data_req/wr/wstrb/addr/wdata     load/store request
//  data_addr_ok                     load/store accept
//  data_data_ok, data_rdata         load data / store completion
//  sram_en/we/addr/wdata, sram_rdata  SRAM port (read data valid cycle after sram_en)
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = DefaultStarveLimit
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inst_req,
  input  logic [AW-1:0]    inst_addr,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [DW-1:0]    inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [StrbW-1:0] data_wstrb,
  input  logic [AW-1:0]    data_addr,
  input  logic [DW-1:0]    data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [DW-1:0]    data_rdata,
  output logic             sram_en,
  output logic [StrbW-1:0] sram_we,
  output logic [AW-1:0]    sram_addr,
  output logic [DW-1:0]    sram_wdata,
  input  logic [DW-1:0]    sram_rdata
);

  localparam int unsigned CntW = cnt_width(STARVE_LIMIT);

  owner_e rsp_owner_d, rsp_owner_q;
  logic   rsp_store_d, rsp_store_q;
  logic   at_limit, force_inst, grant_data, grant_inst;

  // Grants are qualified by resetn so nothing is accepted (or reaches the SRAM)
  // while reset is held, even if a requester keeps its request up.
  always_comb begin
    force_inst = inst_req & data_req & at_limit;
    grant_data = resetn & data_req & ~force_inst;
    grant_inst = resetn & inst_req & ~grant_data;
  end

  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    sram_en      = grant_data | grant_inst;
    sram_addr    = '0;
    sram_wdata   = '0;
    sram_we      = '0;
    rsp_owner_d  = OWN_NONE;
    rsp_store_d  = 1'b0;
    if (grant_data) begin
      sram_addr   = data_addr;
      sram_wdata  = data_wdata;
      sram_we     = data_wr ? data_wstrb : '0;
      rsp_owner_d = OWN_DATA;
      rsp_store_d = data_wr;
    end else if (grant_inst) begin
      sram_addr   = inst_addr;
      rsp_owner_d = OWN_INST;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_owner_q <= OWN_NONE;
      rsp_store_q <= 1'b0;
    end else begin
      rsp_owner_q <= rsp_owner_d;
      rsp_store_q <= rsp_store_d;
    end
  end

  // Stores complete with zero read data; the SRAM output is only steered to its owner.
  always_comb begin
    inst_data_ok = (rsp_owner_q == OWN_INST);
    data_data_ok = (rsp_owner_q == OWN_DATA);
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = (data_data_ok && !rsp_store_q) ? sram_rdata : '0;
  end

  arb_starve_counter #(
    .Limit (STARVE_LIMIT),
    .CntW  (CntW)
  ) u_starve (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .inc_i      (grant_data & inst_req),
    .clr_i      (grant_inst | ~inst_req),
    .at_limit_o (at_limit)
  );

endmodule
